// File: rtl/dff_resp_checker.sv
// Response checker for a D flip-flop with active-low synchronous data reset.
// Predicts dout one cycle ahead, counts compares and mismatches, and offers a req/ack snapshot.
module dff_resp_checker #(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dut_rst,
  input  logic             din,
  input  logic             dout,
  input  logic             en,
  input  logic             clr,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ack,
  output logic [CNT_W-1:0] snap_samples,
  output logic [CNT_W-1:0] snap_errs,
  output logic             halted
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  logic       exp_bit;
  logic       pred;
  logic       miss;
  logic [CNT_W-1:0] err_cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // The flip-flop loads 0 whenever its own reset is asserted at the edge.
  assign pred        = dut_rst ? din : 1'b0;
  assign miss        = dout ^ exp_bit;
  assign err_cnt_inc = sat_inc(err_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      exp_bit       <= 1'b0;
      mismatch      <= 1'b0;
      err           <= 1'b0;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      snap_valid    <= 1'b0;
      snap_samples  <= '0;
      snap_errs     <= '0;
      halted        <= 1'b0;
    end else if (clr) begin
      state         <= IDLE;
      mismatch      <= 1'b0;
      err           <= 1'b0;
      sample_cnt    <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      snap_valid    <= 1'b0;
      snap_samples  <= '0;
      snap_errs     <= '0;
      halted        <= 1'b0;
    end else begin
      mismatch <= 1'b0;

      case (state)
        IDLE: begin
          if (en) begin
            exp_bit <= pred;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (en) begin
            exp_bit    <= pred;
            sample_cnt <= sat_inc(sample_cnt);
            if (miss) begin
              err_cnt  <= err_cnt_inc;
              err      <= 1'b1;
              mismatch <= 1'b1;
              if (!first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_idx <= sample_cnt;
              end
              if (STOP_ON_ERR || (err_cnt_inc == CNT_MAX)) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase

      // Snapshot sees pre-edge counter values; requests are ignored while one is held.
      if (snap_valid) begin
        if (snap_ack) snap_valid <= 1'b0;
      end else if (snap_req) begin
        snap_valid   <= 1'b1;
        snap_samples <= sample_cnt;
        snap_errs    <= err_cnt;
      end
    end
  end

endmodule

// File: doc/dff_resp_checker.md
# dff_resp_checker

Synthesizable response checker for a single-bit D flip-flop with active-low synchronous data reset. It observes the same `din` and DUT reset that drive the flip-flop, predicts the flip-flop output one cycle later, and compares the prediction against the flip-flop's `dout`. It counts samples and mismatches, records the first failing sample, and exposes a snapshot handshake so a bench or host can read stable counts. It sits beside the flip-flop as the observing end of its din/dout interface.

## Interface
- `CNT_W`, default 16: width of the sample and error counters and of the index registers.
- `STOP_ON_ERR`, default 0: when 1, the first mismatch sends the checker to HALT.

Ports:
- `clk`  in  1  clock, shared with the observed flip-flop.
- `rst`  in  1  asynchronous, active-low reset of the checker itself.
- `dut_rst`  in  1  the observed flip-flop's active-low synchronous reset, as driven to it.
- `din`  in  1  the observed flip-flop's data input, as driven to it.
- `dout`  in  1  the observed flip-flop's output.
- `en`  in  1  enables checking.
- `clr`  in  1  synchronous clear of counters, flags, state and snapshot.
- `mismatch`  out  1  one-cycle pulse after a failing compare.
- `err`  out  1  sticky error flag.
- `sample_cnt`  out  CNT_W  number of compares performed.
- `err_cnt`  out  CNT_W  number of failing compares.
- `first_err_vld`  out  1  `first_err_idx` is valid.
- `first_err_idx`  out  CNT_W  value of `sample_cnt` at the first mismatch.
- `snap_req`  in  1  request a snapshot.
- `snap_valid`  out  1  snapshot registers hold valid data.
- `snap_ack`  in  1  consumer has taken the snapshot.
- `snap_samples`  out  CNT_W  snapshot of `sample_cnt`.
- `snap_errs`  out  CNT_W  snapshot of `err_cnt`.
- `halted`  out  1  the checker is in HALT.

## Operation
- Reset (`rst`=0, async): state IDLE; all outputs 0; `exp` = 0.
- Prediction: each edge with `en`=1 outside HALT loads `exp` = `dut_rst` ? `din` : 0.
- State machine:
  - IDLE: if `en`=1, load `exp` and go to CHECK. No compare is made.
  - CHECK: if `en`=1, compare `dout` with `exp`, load a new `exp`, and stay. If `en`=0, go to IDLE with no compare.
  - CHECK, mismatch with `STOP_ON_ERR`=1: go to HALT.
  - CHECK, `err_cnt` reaching all-ones: go to HALT.
  - HALT: no compares and no `exp` loads. Exit only via `clr` or `rst`. `halted`=1.
- Each compare increments `sample_cnt`. `sample_cnt` saturates at 2^CNT_W−1 and, once saturated, holds; compares continue.
- On a failing compare:
  - `err_cnt` increments, saturating.
  - `err` is set and stays set.
  - `mismatch` pulses high for one cycle.
  - If `first_err_vld`=0: `first_err_idx` = pre-increment `sample_cnt` and `first_err_vld` = 1.
- `clr` (sync): highest priority below `rst`. Zeroes counters, `err`, `first_err_*`, `snap_*` and `mismatch`; state goes to IDLE. Any compare due at that edge is discarded.
- Snapshot handshake:
  - Request: `snap_req`=1 with `snap_valid`=0 at an edge latches `snap_samples`/`snap_errs`, taking the counter values present before that edge, and sets `snap_valid`.
  - Hold: `snap_valid` and the snapshot data stay stable until an edge with `snap_ack`=1.
  - Release: `snap_ack`=1 at an edge clears `snap_valid`.
  - `snap_req` while `snap_valid`=1 is ignored, including when it coincides with `snap_ack`.
  - `snap_ack` while `snap_valid`=0 is ignored.
  - The snapshot path works in every state, including HALT.

## Timing
- The compare at edge k+1 uses the `exp` loaded at edge k, which matches the flip-flop's update at edge k.
- Counters, `err`, `mismatch` and `first_err_*` are registered and become visible immediately after the compare edge.
- `mismatch` is high for exactly one cycle per failing compare. Back-to-back failures keep it high continuously.
- `en` falling: the edge where `en`=0 is first sampled performs no compare.
- `en` rising again: one priming edge occurs before compares resume.
- Snapshot latency: `snap_valid` is high one edge after `snap_req` is sampled. Minimum request-to-request turnaround is 2 cycles (req edge, then ack edge).
- Asserting `rst` mid-run clears everything immediately, without a clock. Deassertion is sampled on the next edge.

## Test plan
- Clean run: `dut_rst`=1, `en`=1, `din` pattern 1,0,1,1 with a correct model flip-flop → after 5 edges `sample_cnt`=4, `err_cnt`=0, `err`=0.
- Reset prediction: `dut_rst`=0 with `din`=1 for one edge, flip-flop correct → no mismatch and the expected value for that cycle is 0. Forcing `dout`=1 in the next cycle → `mismatch` pulse, `err_cnt`=1, `first_err_idx` = that sample's index.
- Injected faults with `STOP_ON_ERR`=0: `dout` forced wrong on samples 3 and 7 → `err_cnt`=2, `first_err_idx`=3, `err` stays 1. A later `clr` zeroes all of these.
- `STOP_ON_ERR`=1: fault on sample 2 → `halted`=1 and `sample_cnt` frozen at 3 despite `en`=1. A `snap_req` still returns `snap_samples`=3 and `snap_errs`=1.
- Saturation with `CNT_W`=3: 10 failing compares → `err_cnt`=7, state HALT, `sample_cnt`=7.
- Snapshot handshake: `snap_req` while counters change → snapshot equals the pre-edge values and stays stable over several cycles. `snap_req` together with `snap_ack` while valid → `snap_valid` goes to 0 with no new capture. `rst` pulsed mid-run → every output returns to 0 asynchronously.
